// File: rtl/wb_rom_bridge_if.sv
// Wishbone classic slave bundle for the program-store bridge.
// The master drives the request side and the slave returns the acknowledge and read data.
interface wb_rom_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_rom_bridge.sv
// Wishbone slave bridging bus cycles onto OpenRAM port 0 of the program store, plus a
// control register that holds the core in reset while firmware loads the image.
module wb_rom_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned READ_WAIT = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    wb_rom_bridge_if.slave       wbs,
    output logic                 wb_rom_csb,
    output logic                 wb_rom_web,
    output logic [ADDR_BITS-1:0] wb_rom_adrb,
    input  logic [31:0]          wb_rom_val,
    output logic                 cpu_hold_o
);

    localparam int unsigned CntW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [CntW-1:0] WaitInit = CntW'(READ_WAIT);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

    state_e                 r_state;
    logic [CntW-1:0]        r_wait_cnt;
    logic                   r_csb;
    logic                   r_web;
    logic [ADDR_BITS-1:0]   r_adrb;
    logic                   r_ack;
    logic [31:0]            r_dat_o;
    logic                   r_cpu_hold;
    logic                   r_wp;

    logic                   w_hit;
    logic                   w_req;
    logic                   w_is_ctrl;
    logic [ADDR_BITS-1:0]   w_word;
    logic [31:0]            w_ctrl_val;
    logic                   w_unused;

    assign w_hit      = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & w_hit;
    assign w_is_ctrl  = wbs.wbs_adr_i[11];
    assign w_word     = wbs.wbs_adr_i[ADDR_BITS+1:2];
    assign w_ctrl_val = {30'b0, r_wp, r_cpu_hold};
    // SRAM din0/wmask0 are wired straight from the bus outside this block.
    assign w_unused   = ^{wbs.wbs_dat_i[31:2], wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
            r_csb      <= 1'b1;
            r_web      <= 1'b1;
            r_adrb     <= '0;
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_cpu_hold <= 1'b1;
            r_wp       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        if (w_is_ctrl) begin
                            if (wbs.wbs_we_i) begin
                                if (wbs.wbs_sel_i[0]) begin
                                    r_cpu_hold <= wbs.wbs_dat_i[0];
                                    r_wp       <= wbs.wbs_dat_i[1];
                                end
                            end else begin
                                r_dat_o <= w_ctrl_val;
                            end
                            r_ack   <= 1'b1;
                            r_state <= StAck;
                        end else begin
                            r_adrb <= w_word;
                            if (wbs.wbs_we_i && r_wp) begin
                                // Protected write: acknowledged but never strobed.
                                r_ack   <= 1'b1;
                                r_state <= StAck;
                            end else begin
                                r_csb   <= 1'b0;
                                r_web   <= ~wbs.wbs_we_i;
                                r_state <= StAccess;
                            end
                        end
                    end
                end
                StAccess: begin
                    r_csb <= 1'b1;
                    r_web <= 1'b1;
                    if (!wbs.wbs_cyc_i) begin
                        r_state <= StIdle;
                    end else if (!r_web) begin
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end else begin
                        r_wait_cnt <= WaitInit;
                        r_state    <= StWait;
                    end
                end
                StWait: begin
                    if (!wbs.wbs_cyc_i) begin
                        r_state <= StIdle;
                    end else if (r_wait_cnt == '0) begin
                        r_dat_o <= wb_rom_val;
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                StAck: begin
                    r_ack   <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat_o;
    assign wb_rom_csb    = r_csb;
    assign wb_rom_web    = r_web;
    assign wb_rom_adrb   = r_adrb;
    assign cpu_hold_o    = r_cpu_hold;

endmodule
